md_phase_sequencer: RTL and testbench

//   Parametrised timestep/phase controller for the MD pipeline.

---
 rtl/md_phase_sequencer.sv | 97 +++++++++
 tb/tb_md_phase_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/md_phase_sequencer.sv
// md_phase_sequencer: steps NUM_PHASES done-gated phases per timestep, toggles the position buffer and stops after num_steps timesteps
module md_phase_sequencer #(
    parameter int NUM_PHASES = 2,
    parameter int NUM_UNITS  = 4,
    parameter int T_WIDTH    = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             mem_set,
    input  logic [T_WIDTH-1:0]               num_steps,
    input  logic [NUM_PHASES*NUM_UNITS-1:0]  unit_done,
    output logic [NUM_PHASES-1:0]            phase_ready,
    output logic [NUM_PHASES-1:0]            phase_start,
    output logic [$clog2(NUM_PHASES)-1:0]    phase_idx,
    output logic                             double_buffer,
    output logic [T_WIDTH-1:0]               timestep,
    output logic                             busy,
    output logic                             sim_done
);
    localparam int PW = $clog2(NUM_PHASES);
    localparam logic [PW-1:0] LAST = PW'(NUM_PHASES - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISHED} state_t;

    state_t               state, state_n;
    logic [PW-1:0]        phase_n;
    logic [NUM_UNITS-1:0] latch, latch_n, cur_done;
    logic                 first, first_n, dbuf_n, all_done;
    logic [T_WIDTH-1:0]   ts_n, steps, steps_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            phase_idx     <= '0;
            latch         <= '0;
            first         <= 1'b0;
            double_buffer <= 1'b0;
            timestep      <= '0;
            steps         <= '0;
        end else begin
            state         <= state_n;
            phase_idx     <= phase_n;
            latch         <= latch_n;
            first         <= first_n;
            double_buffer <= dbuf_n;
            timestep      <= ts_n;
            steps         <= steps_n;
        end
    end

    // the arriving done of the last unit completes the phase in the same cycle
    assign cur_done = unit_done[phase_idx*NUM_UNITS +: NUM_UNITS];
    assign all_done = &(latch | cur_done);

    always_comb begin
        state_n = state;
        phase_n = phase_idx;
        latch_n = latch;
        first_n = 1'b0;
        dbuf_n  = double_buffer;
        ts_n    = timestep;
        steps_n = steps;
        case (state)
            IDLE: if (mem_set) begin
                state_n = RUN;
                steps_n = num_steps;
                phase_n = '0;
                latch_n = '0;
                first_n = 1'b1;
            end
            RUN: begin
                latch_n = latch | cur_done;
                if (all_done && mem_set) begin
                    latch_n = '0;
                    first_n = 1'b1;
                    if (phase_idx == LAST) begin
                        phase_n = '0;
                        dbuf_n  = ~double_buffer;
                        ts_n    = timestep + T_WIDTH'(1);
                        if (steps != '0 && ts_n == steps) begin
                            state_n = FINISHED;
                            first_n = 1'b0;
                        end
                    end else begin
                        phase_n = phase_idx + PW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign phase_ready = (state == RUN) ? (NUM_PHASES'(1) << phase_idx) : '0;
    assign phase_start = first ? phase_ready : '0;
    assign busy        = state == RUN;
    assign sim_done    = state == FINISHED;
endmodule

// File: tb/tb_md_phase_sequencer.sv
// tb_md_phase_sequencer: directed vectors for the phase sequencer (4 units) and a 4-bit-counter legacy instance
module tb_md_phase_sequencer;
    logic        clk = 1'b0;
    logic        reset, mem_set;
    logic [15:0] num_steps;
    logic [7:0]  unit_done;
    logic [1:0]  phase_ready, phase_start;
    logic [0:0]  phase_idx;
    logic        double_buffer, busy, sim_done;
    logic [15:0] timestep;

    logic        reset5, mem_set5;
    logic [3:0]  num_steps5;
    logic [1:0]  unit_done5, phase_ready5, phase_start5;
    logic [0:0]  phase_idx5;
    logic        double_buffer5, busy5, sim_done5;
    logic [3:0]  timestep5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    md_phase_sequencer #(.NUM_PHASES(2), .NUM_UNITS(4), .T_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .mem_set(mem_set), .num_steps(num_steps),
        .unit_done(unit_done), .phase_ready(phase_ready), .phase_start(phase_start),
        .phase_idx(phase_idx), .double_buffer(double_buffer), .timestep(timestep),
        .busy(busy), .sim_done(sim_done)
    );

    md_phase_sequencer #(.NUM_PHASES(2), .NUM_UNITS(1), .T_WIDTH(4)) dut5 (
        .clk(clk), .reset(reset5), .mem_set(mem_set5), .num_steps(num_steps5),
        .unit_done(unit_done5), .phase_ready(phase_ready5), .phase_start(phase_start5),
        .phase_idx(phase_idx5), .double_buffer(double_buffer5), .timestep(timestep5),
        .busy(busy5), .sim_done(sim_done5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"}, 32'(phase_ready), 0);
        check({tag, " start"}, 32'(phase_start), 0);
        check({tag, " idx"}, 32'(phase_idx), 0);
        check({tag, " dbuf"}, 32'(double_buffer), 0);
        check({tag, " ts"}, 32'(timestep), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(sim_done), 0);
    endtask

    function automatic logic [7:0] stagger(input int k);
        return (k == 2) ? 8'h01 : (k == 5) ? 8'h06 : (k == 9) ? 8'h08 : 8'h00;
    endfunction

    initial begin
        reset = 1'b1; mem_set = 1'b0; num_steps = '0; unit_done = '0;
        reset5 = 1'b1; mem_set5 = 1'b0; num_steps5 = '0; unit_done5 = 2'b11;
        tick(); tick();
        check_reset_outputs("rst");

        // 1) three timesteps, all units pulse 2 cycles after phase_start
        reset = 1'b0; num_steps = 16'd3; mem_set = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < 2; p++) begin
                check("t1 idx", 32'(phase_idx), 32'(p));
                check("t1 ready", 32'(phase_ready), 32'(1 << p));
                check("t1 start", 32'(phase_start), 32'(1 << p));
                check("t1 busy", 32'(busy), 1);
                tick();
                check("t1 start once", 32'(phase_start), 0);
                tick();
                unit_done = 8'h0F << (4 * p);
                tick();
                unit_done = '0;
                if (p == 1) begin
                    check("t1 ts", 32'(timestep), 32'(s + 1));
                    check("t1 dbuf", 32'(double_buffer), 32'((s + 1) & 1));
                end
            end
        end
        check("t1 sim_done", 32'(sim_done), 1);
        check("t1 fin ready", 32'(phase_ready), 0);
        check("t1 fin busy", 32'(busy), 0);
        check("t1 fin start", 32'(phase_start), 0);
        unit_done = 8'hFF;
        repeat (3) tick();
        unit_done = '0;
        check("t1 frozen ts", 32'(timestep), 3);
        check("t1 frozen dbuf", 32'(double_buffer), 1);
        check("t1 held done", 32'(sim_done), 1);

        // 2) staggered unit completion in phase 0
        reset = 1'b1; num_steps = '0;
        tick();
        reset = 1'b0;
        tick();
        for (int k = 0; k <= 12; k++) begin
            unit_done = stagger(k);
            check("t2 ready", 32'(phase_ready), (k <= 9) ? 1 : 2);
            if (k == 10) check("t2 start", 32'(phase_start), 2);
            tick();
        end

        // 3) done bits of the other phase are ignored
        unit_done = 8'hF0;
        tick();
        unit_done = '0;
        check("t3 idx0", 32'(phase_idx), 0);
        check("t3 ts", 32'(timestep), 1);
        check("t3 dbuf", 32'(double_buffer), 1);
        unit_done = 8'hF0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3 wrong phase", 32'(phase_idx), 0);
        end
        unit_done = 8'hF7;
        tick();
        check("t3 partial", 32'(phase_idx), 0);
        unit_done = 8'h08;
        tick();
        unit_done = '0;
        check("t3 advance", 32'(phase_idx), 1);
        check("t3 start", 32'(phase_start), 2);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3 empty latch", 32'(phase_idx), 1);
        end
        unit_done = 8'h70;
        tick();
        unit_done = '0;
        check("t3 p1 partial", 32'(phase_idx), 1);
        tick();
        check("t3 p1 hold", 32'(phase_idx), 1);
        unit_done = 8'h80;
        tick();
        unit_done = '0;
        check("t3 p1 done", 32'(phase_idx), 0);
        check("t3 ts2", 32'(timestep), 2);
        check("t3 dbuf0", 32'(double_buffer), 0);

        // 4) pause in phase 1 with everything done
        unit_done = 8'h0F;
        tick();
        unit_done = '0;
        check("t4 enter p1", 32'(phase_idx), 1);
        unit_done = 8'hF0; mem_set = 1'b0;
        tick();
        unit_done = '0;
        for (int k = 0; k < 4; k++) begin
            check("t4 idx held", 32'(phase_idx), 1);
            check("t4 ready held", 32'(phase_ready), 2);
            check("t4 no restart", 32'(phase_start), 0);
            check("t4 ts held", 32'(timestep), 2);
            check("t4 dbuf held", 32'(double_buffer), 0);
            if (k < 3) tick();
        end
        mem_set = 1'b1;
        tick();
        check("t4 resume idx", 32'(phase_idx), 0);
        check("t4 resume ts", 32'(timestep), 3);
        check("t4 resume dbuf", 32'(double_buffer), 1);
        check("t4 resume start", 32'(phase_start), 1);

        // 6) reset mid phase 1 of the second timestep
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        unit_done = 8'h0F; tick();
        unit_done = 8'hF0; tick();
        unit_done = 8'h0F; tick();
        unit_done = '0;
        check("t6 pre idx", 32'(phase_idx), 1);
        check("t6 pre ts", 32'(timestep), 1);
        reset = 1'b1; unit_done = 8'hF0;
        tick();
        check_reset_outputs("t6 rst");
        reset = 1'b0; unit_done = '0;
        tick();
        check("t6 restart idx", 32'(phase_idx), 0);
        check("t6 restart start", 32'(phase_start), 1);
        check("t6 restart ts", 32'(timestep), 0);
        check("t6 restart dbuf", 32'(double_buffer), 0);

        // 5) free-running 4-bit counter wraps and never finishes
        reset5 = 1'b0; mem_set5 = 1'b1;
        tick();
        for (int t = 1; t <= 17; t++) begin
            tick(); tick();
            check("t5 ts", 32'(timestep5), 32'(t % 16));
            check("t5 dbuf", 32'(double_buffer5), 32'(t & 1));
            check("t5 not done", 32'(sim_done5), 0);
            check("t5 start", 32'(phase_start5), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
